// File: rtl/mem_burst_ctrl_if.sv
// Request, line-buffer and memory-port bundle for mem_burst_ctrl.
// MEM_BURST_WRAP_EN adds req_word for critical-word-first bursts.
interface mem_burst_ctrl_if #(
  parameter int unsigned ADDR_LEN       = 11,
  parameter int unsigned LINE_WORDS_LEN = 3
);
  localparam int unsigned LINE_LEN = ADDR_LEN - LINE_WORDS_LEN;
  localparam int unsigned DATA_W   = 32;

  // requester side
  logic                      req;
  logic                      req_wr;
  logic [LINE_LEN-1:0]       req_line;
`ifdef MEM_BURST_WRAP_EN
  logic [LINE_WORDS_LEN-1:0] req_word;
`endif
  logic                      busy;
  logic                      done;
  logic [LINE_WORDS_LEN-1:0] wbuf_idx;
  logic [DATA_W-1:0]         wbuf_data;
  logic                      rbuf_we;
  logic [LINE_WORDS_LEN-1:0] rbuf_idx;
  logic [DATA_W-1:0]         rbuf_data;

  // memory side
  logic [ADDR_LEN-1:0]       mem_addr;
  logic                      mem_wr_req;
  logic [DATA_W-1:0]         mem_wr_data;
  logic [DATA_W-1:0]         mem_rd_data;

  modport master (
    input  req, req_wr, req_line, wbuf_data, mem_rd_data,
`ifdef MEM_BURST_WRAP_EN
    input  req_word,
`endif
    output busy, done, wbuf_idx, rbuf_we, rbuf_idx, rbuf_data,
    output mem_addr, mem_wr_req, mem_wr_data
  );

  modport slave (
    output req, req_wr, req_line, wbuf_data, mem_rd_data,
`ifdef MEM_BURST_WRAP_EN
    output req_word,
`endif
    input  busy, done, wbuf_idx, rbuf_we, rbuf_idx, rbuf_data,
    input  mem_addr, mem_wr_req, mem_wr_data
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Line-burst initiator: one line read/write request becomes 2**LINE_WORDS_LEN word accesses.
// Optional critical-word-first ordering under MEM_BURST_WRAP_EN.
module mem_burst_ctrl #(
  parameter int unsigned ADDR_LEN       = 11,
  parameter int unsigned LINE_WORDS_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_burst_ctrl_if.master bus
);
  localparam int unsigned LINE_LEN = ADDR_LEN - LINE_WORDS_LEN;
  localparam int unsigned DATA_W   = 32;
  localparam logic [LINE_WORDS_LEN-1:0] LAST_CNT = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [LINE_WORDS_LEN-1:0] cnt;
  logic [LINE_LEN-1:0]       line_q;
  logic [LINE_WORDS_LEN-1:0] word_idx;
  logic                      rd_valid_q;
  logic [LINE_WORDS_LEN-1:0] rd_idx_q;
  logic                      accept;

  assign accept = (state == S_IDLE) && bus.req;

`ifdef MEM_BURST_WRAP_EN
  logic [LINE_WORDS_LEN-1:0] word_base;

  // Start word latched with the request; index wraps within the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_base <= '0;
    end else if (accept) begin
      word_base <= bus.req_word;
    end
  end

  assign word_idx = LINE_WORDS_LEN'(word_base + cnt);
`else
  assign word_idx = cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst counter, latched line, and the one-cycle-delayed read return tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      line_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        line_q <= bus.req_line;
      end else if ((state == S_WRITE) || (state == S_READ)) begin
        cnt <= LINE_WORDS_LEN'(cnt + LINE_WORDS_LEN'(1));
      end
      rd_valid_q <= (state == S_READ);
      rd_idx_q   <= word_idx;
    end
  end

  // Read data goes straight through; memory already registers it.
  assign bus.rbuf_data = bus.mem_rd_data;

  always_comb begin
    state_nxt       = state;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.wbuf_idx    = '0;
    bus.rbuf_we     = 1'b0;
    bus.rbuf_idx    = '0;
    bus.mem_addr    = '0;
    bus.mem_wr_req  = 1'b0;
    bus.mem_wr_data = '0;

    case (state)
      S_IDLE: begin
        if (bus.req) begin
          state_nxt = bus.req_wr ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        bus.busy        = 1'b1;
        bus.mem_addr    = {line_q, word_idx};
        bus.wbuf_idx    = word_idx;
        bus.mem_wr_req  = 1'b1;
        bus.mem_wr_data = DATA_W'(bus.wbuf_data);
        if (cnt == LAST_CNT) begin
          state_nxt = S_DONE;
        end
      end

      S_READ: begin
        bus.busy     = 1'b1;
        bus.mem_addr = {line_q, word_idx};
        bus.rbuf_we  = rd_valid_q;
        bus.rbuf_idx = rd_valid_q ? rd_idx_q : '0;
        if (cnt == LAST_CNT) begin
          state_nxt = S_DRAIN;
        end
      end

      // Last address was issued in READ; its data arrives now.
      S_DRAIN: begin
        bus.busy     = 1'b1;
        bus.rbuf_we  = 1'b1;
        bus.rbuf_idx = rd_idx_q;
        state_nxt    = S_DONE;
      end

      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end
endmodule
